// File: rtl/float16_accumulator_if.sv
// Operand and result handshake bundle for float16_accumulator.
// master drives operands and result-ready; slave is the accumulator.
interface float16_accumulator_if #(
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic [15:0]      in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic [15:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/float16_accumulator.sv
// Sequential float16 accumulator: one operand per four cycles, truncating adder.
// Define FP16_ACC_SPECIAL_EN to honour Inf/NaN; otherwise exponent-31 inputs saturate.
module float16_accumulator #(
    parameter int unsigned CNT_W = 8
) (
    input logic                  clk,
    input logic                  rst,
    float16_accumulator_if.slave bus
);

`ifdef FP16_ACC_SPECIAL_EN
    localparam bit SpecialEn = 1'b1;
`else
    localparam bit SpecialEn = 1'b0;
`endif

    localparam logic [14:0] OvfMag = SpecialEn ? 15'h7C00 : 15'h7BFF;

    typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StDone} state_e;

    state_e           state_q, state_d;
    logic [15:0]      acc_q, op_q, out_data_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt_q;

    // Align-stage results
    logic             big_sign_q, small_sign_q;
    logic [4:0]       big_exp_q;
    logic [13:0]      big_man_q, small_man_q;

    // Add-stage results
    logic [14:0]      sum_q;
    logic             sum_sign_q;
    logic [4:0]       sum_exp_q;

    // Subnormals become +0; without special handling exponent 31 saturates.
    function automatic logic [15:0] sanitize(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[14:10] == 5'd0) begin
            r = 16'h0000;
        end else if (!SpecialEn && v[14:10] == 5'd31) begin
            r = {v[15], 15'h7BFF};
        end
        return r;
    endfunction

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid) state_d = StAlign;
            StAlign: state_d = StAdd;
            StAdd:   state_d = StNorm;
            StNorm:  state_d = last_q ? StDone : StIdle;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------- align ----------------
    logic        acc_big;
    logic [15:0] big_v, small_v;
    logic [4:0]  exp_diff;
    logic [13:0] big_full, small_full, small_al;

    always_comb begin
        // Larger magnitude wins ties toward the accumulator so subtraction never goes negative
        acc_big    = acc_q[14:0] >= op_q[14:0];
        big_v      = acc_big ? acc_q : op_q;
        small_v    = acc_big ? op_q : acc_q;
        exp_diff   = big_v[14:10] - small_v[14:10];
        big_full   = (big_v[14:10] != 5'd0) ? {1'b1, big_v[9:0], 3'b000} : 14'd0;
        small_full = (small_v[14:10] != 5'd0) ? {1'b1, small_v[9:0], 3'b000} : 14'd0;
        small_al   = (exp_diff >= 5'd13) ? 14'd0 : (small_full >> exp_diff);
    end

    // ---------------- add ----------------
    logic        sub_op;
    logic [14:0] sum_d;
    logic        sum_sign_d;

    always_comb begin
        sub_op     = big_sign_q ^ small_sign_q;
        sum_d      = sub_op ? ({1'b0, big_man_q} - {1'b0, small_man_q})
                            : ({1'b0, big_man_q} + {1'b0, small_man_q});
        sum_sign_d = (sub_op && sum_d == 15'd0) ? 1'b0 : big_sign_q;
    end

    // ---------------- normalise ----------------
    logic [3:0]        lz;
    logic [13:0]       norm_man;
    logic signed [6:0] exp_n;
    logic [15:0]       norm_res;
    logic              a_nan, a_inf, b_nan, b_inf;

    always_comb begin
        lz = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (sum_q[i]) lz = 4'(13 - i);
        end
        if (sum_q[14]) begin
            norm_man = sum_q[14:1];
            exp_n    = $signed({2'b00, sum_exp_q}) + 7'sd1;
        end else begin
            norm_man = sum_q[13:0] << lz;
            exp_n    = $signed({2'b00, sum_exp_q}) - $signed({3'b000, lz});
        end

        if (sum_q == 15'd0 || exp_n < 7'sd1) begin
            norm_res = {sum_sign_q, 15'd0};
        end else if (exp_n >= 7'sd31) begin
            norm_res = {sum_sign_q, OvfMag};
        end else begin
            norm_res = {sum_sign_q, exp_n[4:0], norm_man[12:3]};
        end

        a_nan = (acc_q[14:10] == 5'd31) && (acc_q[9:0] != 10'd0);
        a_inf = (acc_q[14:10] == 5'd31) && (acc_q[9:0] == 10'd0);
        b_nan = (op_q[14:10] == 5'd31) && (op_q[9:0] != 10'd0);
        b_inf = (op_q[14:10] == 5'd31) && (op_q[9:0] == 10'd0);
        // Special values override the arithmetic path; NaN and Inf stay sticky in acc_q
        if (SpecialEn) begin
            if (a_nan || b_nan || (a_inf && b_inf && (acc_q[15] != op_q[15]))) begin
                norm_res = 16'h7E00;
            end else if (a_inf) begin
                norm_res = acc_q;
            end else if (b_inf) begin
                norm_res = {op_q[15], 15'h7C00};
            end
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            acc_q        <= 16'h0000;
            op_q         <= 16'h0000;
            last_q       <= 1'b0;
            cnt_q        <= '0;
            out_data_q   <= 16'h0000;
            big_sign_q   <= 1'b0;
            small_sign_q <= 1'b0;
            big_exp_q    <= 5'd0;
            big_man_q    <= 14'd0;
            small_man_q  <= 14'd0;
            sum_q        <= 15'd0;
            sum_sign_q   <= 1'b0;
            sum_exp_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && bus.in_valid) begin
                op_q   <= sanitize(bus.in_data);
                last_q <= bus.in_last;
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            if (state_q == StAlign) begin
                big_sign_q   <= big_v[15];
                small_sign_q <= small_v[15];
                big_exp_q    <= big_v[14:10];
                big_man_q    <= big_full;
                small_man_q  <= small_al;
            end
            if (state_q == StAdd) begin
                sum_q      <= sum_d;
                sum_sign_q <= sum_sign_d;
                sum_exp_q  <= big_exp_q;
            end
            if (state_q == StNorm) begin
                acc_q <= norm_res;
                if (last_q) out_data_q <= norm_res;
            end
            if (state_q == StDone && bus.out_ready) begin
                acc_q <= 16'h0000;
                cnt_q <= '0;
            end
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_data  = out_data_q;
    assign bus.out_count = cnt_q;

endmodule
